sdc_cmd_send: RTL and testbench
===============================

Name: sdc_cmd_send

Overview:
SPI-mode SD card command transmitter. It serialises one 48-bit SD command frame (start/transmission bits, 6-bit command index, 32-bit argument, CRC7, end bit) onto MOSI, MSB first. It also generates the SCK-enable state for the shared SCK gate. It is the transmit-side counterpart of the SD response receiver, and the card-init/read sequencer drives it.

Parameters:
CRC_GEN, 1, 1 = compute CRC7 internally over the first 40 bits; 0 = use i_crc latched at start
FRAME_BITS, 48, frame length in bits; fixed by the SD spec and not intended to be overridden

Ports:
i_clk  input  1  system clock; also the SCK source when gated by o_sck_state
i_rst_n  input  1  asynchronous, active-low reset
i_we  input  1  start request; sampled only when idle
i_cmd  input  6  command index (CMD0..CMD63)
i_arg  input  32  command argument
i_crc  input  7  external CRC7; used only when CRC_GEN=0
o_mosi  output  1  serial data to card
o_sck_state  output  1  high while frame bits are on MOSI; enables the SCK gate
o_busy  output  1  frame in progress
o_done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset:
  - One clock, i_clk. Reset is asynchronous, active-low (i_rst_n).
  - All sequential logic updates on the falling edge of i_clk, so MOSI changes on SCK falling edges and the card samples on rising edges.
  - Reset values: o_mosi=1, o_sck_state=0, o_busy=0, o_done=0, bit counter=0, CRC register=0, state=IDLE.
- Frame layout, transmitted bit 47 first:
  - byte0 = {1'b0, 1'b1, i_cmd}
  - bytes1-4 = i_arg[31:0], MSB first
  - byte5 = {crc7, 1'b1}
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0, computed over frame bits 47..8.
  - With CRC_GEN=1 it is computed bit-serially as bits shift out and complete before bit 7 is presented.
  - With CRC_GEN=0, i_crc is latched at the start edge.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE:
    - o_mosi=1, o_sck_state=0, o_done=0, o_busy=0.
    - If i_we=1 at falling edge E0: latch i_cmd, i_arg (and i_crc), clear the counter and CRC, drive o_mosi=frame bit 47 (0), set o_sck_state=1, o_busy=1, go to SHIFT.
  - SHIFT:
    - At edge E0+k (k=1..47), o_mosi = frame bit 47-k.
    - Each bit is held for exactly one i_clk period, giving 48 SCK pulses total.
    - At E0+48: o_mosi=1, o_sck_state=0, go to DONE.
  - DONE:
    - At E0+49: o_done=1, o_busy=0, go to IDLE.
    - o_done clears at E0+50.
- Input handling:
  - i_we is ignored in SHIFT and DONE.
  - i_cmd, i_arg and i_crc changes after E0 have no effect on the frame in flight.
  - i_we high at E0+50 (the IDLE edge that clears o_done) starts a new frame on that edge. Back-to-back frames are therefore separated by 2 idle-high MOSI cycles.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). No partial end bit is sent. The next frame starts cleanly.
- Counter: 6 bits; no wrap occurs within a frame.

Test Plan:
- Reset: hold i_rst_n=0 mid-clock -> o_mosi=1, o_sck_state=0, o_busy=0, o_done=0 immediately; release with i_we=0 -> outputs unchanged for 10 cycles.
- CMD0: i_cmd=0, i_arg=0 -> bytes captured on SCK rising edges = 40 00 00 00 00 95; exactly 48 cycles with o_sck_state=1; o_done high for one cycle at E0+49.
- CMD8: i_cmd=8, i_arg=32'h000001AA -> 48 00 00 01 AA 87. Pulse i_we again at bit 20 and change i_arg to 0 -> frame unchanged, no second frame.
- Back-to-back: CMD55 arg 0, then CMD41 arg 32'h40000000 with i_we held high -> 77 00 00 00 00 65, then 69 40 00 00 00 77 starting at E0+50; o_busy low for exactly one cycle between frames.
- Reset mid-frame: assert i_rst_n=0 after 20 bits -> o_sck_state=0 and o_mosi=1 at once; a following CMD0 frame is correct (…95).
- CRC_GEN=0: i_cmd=17, i_arg=0, i_crc=7'h3F -> last byte 0x7F, first byte 0x51.

Source files
------------

// File: rtl/sdc_cmd_send.sv
`default_nettype none
// ============================================================================
// sdc_cmd_send : SPI-mode SD command frame transmitter (48-bit, MSB first)
// Revision     : 1.0
// ============================================================================
module sdc_cmd_send #(
    parameter bit CRC_GEN    = 1'b1,
    parameter int FRAME_BITS = 48
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_we,
    input  logic [5:0]  i_cmd,
    input  logic [31:0] i_arg,
    input  logic [6:0]  i_crc,
    output logic        o_mosi,
    output logic        o_sck_state,
    output logic        o_busy,
    output logic        o_done
);

    // Bit positions (counted from the first bit) where the CRC, end bit and
    // the post-frame idle begin.
    localparam logic [5:0] CRC_START = 6'(FRAME_BITS - 8);
    localparam logic [5:0] END_BIT   = 6'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [38:0] data, data_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [6:0]  crc, crc_nxt;
    logic        mosi_nxt, sck_nxt, busy_nxt, done_nxt;
    logic [5:0]  bit_idx;
    logic        fb;

    // SCK is the gated i_clk, so MOSI must move on the falling edge.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            data        <= '0;
            cnt         <= '0;
            crc         <= '0;
            o_mosi      <= 1'b1;
            o_sck_state <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_nxt;
            data        <= data_nxt;
            cnt         <= cnt_nxt;
            crc         <= crc_nxt;
            o_mosi      <= mosi_nxt;
            o_sck_state <= sck_nxt;
            o_busy      <= busy_nxt;
            o_done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        cnt_nxt   = cnt;
        crc_nxt   = crc;
        mosi_nxt  = o_mosi;
        sck_nxt   = o_sck_state;
        busy_nxt  = o_busy;
        done_nxt  = 1'b0;
        bit_idx   = cnt + 6'd1;
        fb        = data[38] ^ crc[6];

        case (state)
            IDLE: begin
                mosi_nxt = 1'b1;
                sck_nxt  = 1'b0;
                busy_nxt = 1'b0;
                if (i_we) begin
                    // The start bit (0) goes out now; it leaves a zero CRC unchanged.
                    data_nxt  = {1'b1, i_cmd, i_arg};
                    cnt_nxt   = '0;
                    crc_nxt   = CRC_GEN ? 7'd0 : i_crc;
                    mosi_nxt  = 1'b0;
                    sck_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                cnt_nxt = bit_idx;
                if (bit_idx < CRC_START) begin
                    mosi_nxt = data[38];
                    data_nxt = {data[37:0], 1'b0};
                    if (CRC_GEN)
                        crc_nxt = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
                end else if (bit_idx < END_BIT) begin
                    mosi_nxt = crc[6];
                    crc_nxt  = {crc[5:0], 1'b0};
                end else if (bit_idx == END_BIT) begin
                    mosi_nxt = 1'b1;
                end else begin
                    mosi_nxt  = 1'b1;
                    sck_nxt   = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sdc_cmd_send.sv
`default_nettype none
// ============================================================================
// tb_sdc_cmd_send : scoreboard bench for sdc_cmd_send (both CRC modes)
// Revision        : 1.0
// ============================================================================
module tb_sdc_cmd_send;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, we_x;
    logic [5:0]  cmd, cmd_x;
    logic [31:0] arg, arg_x;
    logic [6:0]  crc_in, crc_x;
    logic        mosi, sck, busy, done;
    logic        mosi_x, sck_x, busy_x, done_x;

    int tests = 0;
    int fails = 0;
    int n_exp = 0;
    int n_exp_x = 0;
    int done_cnt = 0;
    int done_cnt_x = 0;
    logic b2b = 1'b0;
    logic [47:0] exp_q[$];
    logic [47:0] exp_qx[$];

    sdc_cmd_send #(.CRC_GEN(1'b1), .FRAME_BITS(48)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_cmd(cmd), .i_arg(arg),
        .i_crc(crc_in), .o_mosi(mosi), .o_sck_state(sck), .o_busy(busy), .o_done(done)
    );

    sdc_cmd_send #(.CRC_GEN(1'b0), .FRAME_BITS(48)) dut_x (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we_x), .i_cmd(cmd_x), .i_arg(arg_x),
        .i_crc(crc_x), .o_mosi(mosi_x), .o_sck_state(sck_x), .o_busy(busy_x), .o_done(done_x)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference frame: fields concatenated, CRC7 by polynomial long division.
    function automatic logic [47:0] frame_of(input logic [5:0] c, input logic [31:0] a);
        logic [39:0] body;
        logic [6:0]  r;
        body = {2'b01, c, a};
        r = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            logic top;
            top = body[i] ^ r[6];
            r = {r[5:0], 1'b0};
            if (top) r = r ^ 7'h09;
        end
        return {body, r, 1'b1};
    endfunction

    // Monitor for the CRC-generating instance: frame content plus end-of-frame timing.
    int nb = 0;
    int post = 0;
    logic [47:0] sh;
    always @(posedge clk) begin
        if (done) done_cnt++;
        if (post == 1) begin
            chk("idle_after_frame", {45'd0, sck, mosi, done}, 48'b010);
            post = 2;
        end else if (post == 2) begin
            chk("done_pulse", {46'd0, done, busy}, 48'b10);
            post = 3;
        end else if (post == 3) begin
            chk("done_clear", {47'd0, done}, 48'd0);
            if (b2b) chk("b2b_restart", {46'd0, busy, sck}, 48'b11);
            post = 0;
        end
        if (rst_n && sck) begin
            sh = {sh[46:0], mosi};
            nb++;
            if (nb == 48) begin
                nb = 0;
                post = 1;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame: got %h expected none", sh);
                end else begin
                    chk("frame", sh, exp_q.pop_front());
                end
            end
        end else begin
            nb = 0;
        end
    end

    // Monitor for the external-CRC instance.
    int nbx = 0;
    logic [47:0] shx;
    always @(posedge clk) begin
        if (done_x) done_cnt_x++;
        if (rst_n && sck_x) begin
            shx = {shx[46:0], mosi_x};
            nbx++;
            if (nbx == 48) begin
                nbx = 0;
                if (exp_qx.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame_x: got %h expected none", shx);
                end else begin
                    chk("frame_x", shx, exp_qx.pop_front());
                end
            end
        end else begin
            nbx = 0;
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(posedge clk);
        while (busy && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 48'd1, 48'd0);
    endtask

    task automatic send(input logic [5:0] c, input logic [31:0] a, input logic [47:0] e);
        wait_idle();
        cmd = c; arg = a; we = 1'b1;
        exp_q.push_back(e);
        n_exp++;
        @(posedge clk);
        we = 1'b0;
        cmd = 6'($urandom);
        arg = $urandom;
    endtask

    initial begin
        rst_n = 1'b1; we = 1'b0; cmd = '0; arg = '0; crc_in = '0;
        we_x = 1'b0; cmd_x = '0; arg_x = '0; crc_x = '0;

        // Asynchronous reset asserted between clock edges.
        #3 rst_n = 1'b0;
        #1 chk("reset_outputs", {44'd0, mosi, sck, busy, done}, 48'b1000);
        chk("reset_outputs_x", {44'd0, mosi_x, sck_x, busy_x, done_x}, 48'b1000);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            chk("idle_hold", {44'd0, mosi, sck, busy, done}, 48'b1000);
        end

        // CMD0 alongside CMD17 on the external-CRC instance.
        we_x = 1'b1; cmd_x = 6'd17; arg_x = 32'd0; crc_x = 7'h3F;
        exp_qx.push_back(48'h51_0000_0000_7F);
        n_exp_x++;
        send(6'd0, 32'd0, 48'h40_0000_0000_95);
        we_x = 1'b0; cmd_x = 6'd2; arg_x = 32'hFFFF_FFFF; crc_x = 7'h00;

        // CMD8 with a stray start request and argument change mid-frame.
        send(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87);
        repeat (19) @(posedge clk);
        cmd = 6'd8; arg = 32'd0; we = 1'b1;
        @(posedge clk);
        we = 1'b0;

        // Back-to-back CMD55 then CMD41 with start held high.
        wait_idle();
        cmd = 6'd55; arg = 32'd0; we = 1'b1;
        exp_q.push_back(48'h77_0000_0000_65);
        n_exp++;
        @(posedge clk);
        cmd = 6'd41; arg = 32'h4000_0000;
        exp_q.push_back(48'h69_4000_0000_77);
        n_exp++;
        b2b = 1'b1;
        repeat (50) @(posedge clk);
        we = 1'b0;
        @(posedge clk);
        b2b = 1'b0;

        // Randomised commands against the reference model.
        for (int i = 0; i < 6; i++) begin
            logic [5:0]  c;
            logic [31:0] a;
            c = 6'($urandom_range(0, 63));
            a = $urandom;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(c, a, frame_of(c, a));
        end

        // A random external-CRC frame.
        begin
            logic [5:0]  c;
            logic [31:0] a;
            logic [6:0]  r;
            c = 6'($urandom); a = $urandom; r = 7'($urandom);
            @(posedge clk);
            we_x = 1'b1; cmd_x = c; arg_x = a; crc_x = r;
            exp_qx.push_back({2'b01, c, a, r, 1'b1});
            n_exp_x++;
            @(posedge clk);
            we_x = 1'b0; crc_x = ~r;
        end

        // Reset in the middle of a frame, then a clean CMD0.
        send(6'd0, 32'h1234_5678, frame_of(6'd0, 32'h1234_5678));
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        exp_qx.delete();
        n_exp--;
        n_exp_x = 0;
        done_cnt_x = 0;
        #1 chk("midframe_reset", {44'd0, mosi, sck, busy, done}, 48'b1000);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        send(6'd0, 32'd0, 48'h40_0000_0000_95);

        // Drain the scoreboards.
        for (int k = 0; k < 200 && (exp_q.size() != 0 || busy || done); k++)
            @(posedge clk);
        repeat (4) @(posedge clk);
        chk("queue_drained", 48'(exp_q.size()), 48'd0);
        chk("queue_drained_x", 48'(exp_qx.size()), 48'd0);
        chk("done_count", 48'(done_cnt), 48'(n_exp));
        chk("done_count_x", 48'(done_cnt_x), 48'(n_exp_x));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
